stack_lifo_param: RTL and testbench
===================================

# stack_lifo_param

Parametrised synchronous LIFO stack, the successor to the lab's fixed 4-bit × 8 stack. It adds configurable width and depth, an occupancy count, and an almost-full threshold. It supports simultaneous push+pop (swap), a combinational peek of the top entry, a synchronous flush, and sticky overflow/underflow error flags. Status flags are derived from the registered pointer, so they are exact on every cycle with no one-cycle lag. It sits between a producer datapath and a consumer FSM in the lab designs.

## Interface
- WIDTH, 4: data word width in bits (≥1)
- DEPTH, 8: number of entries (≥2, any integer, not restricted to a power of two)
- AFULL_LEVEL, DEPTH-1: count at or above which almost_full asserts (1..DEPTH)
- Derived: CW = $clog2(DEPTH+1), the width of count
---
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  reset, synchronous, active-high
- push  input  1  push request
- pop  input  1  pop request
- flush  input  1  synchronous empty-the-stack request
- err_clr  input  1  clears overflow/underflow
- data_in  input  WIDTH  word to push
- data_out  output  WIDTH  registered popped word; holds its value between pops
- pop_valid  output  1  one-cycle pulse: data_out updated this cycle
- top  output  WIDTH  combinational peek of mem[count-1]; 0 when empty
- count  output  CW  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AFULL_LEVEL
- overflow  output  1  sticky: a push was rejected
- underflow  output  1  sticky: a pop was rejected

## Operation
- Priority per edge: rst > flush > push/pop decode. err_clr is evaluated independently of these.
- rst=1: count=0, data_out=0, pop_valid=0, overflow=0, underflow=0. Memory contents are not reset; top reads 0 because the stack is empty.
- flush=1 (rst=0): count←0 and pop_valid←0. data_out and the error flags hold. push and pop in the same cycle are ignored.
- push only, not full: mem[count]←data_in; count←count+1.
- push only, full: no state change; overflow←1.
- pop only, not empty: data_out←mem[count-1]; count←count-1; pop_valid←1.
- pop only, empty: no state change; underflow←1; pop_valid←0.
- push and pop, not empty (swap): data_out←mem[count-1]; mem[count-1]←data_in; count unchanged; pop_valid←1. This is legal even when full and never sets overflow.
- push and pop, empty (pass-through): data_out←data_in; pop_valid←1; count stays 0; no error flag.
- Neither push nor pop: pop_valid←0; everything else holds.
- err_clr=1: overflow←0 and underflow←0. If a new error occurs in the same cycle, the error wins and the flag sets.
- full, empty and almost_full are pure decodes of the count register. count never exceeds DEPTH and never wraps below 0.

## Timing
- Pop latency is 1 cycle: the request is sampled at edge N, and data_out and pop_valid are valid after edge N until edge N+1.
- top is combinational from count and memory. It reflects a push sampled at edge N immediately after that edge.
- Status flags, count and top all change on the same edge as the operation that causes them.
- Back-to-back pushes or pops are accepted every cycle, with no bubbles.
- Reset mid-operation: a pending request in the reset cycle is discarded, and the post-reset state is exactly as listed above.

## Test plan
Directed scenarios for WIDTH=4, DEPTH=8, AFULL_LEVEL=7:
- Reset: assert rst for 2 cycles with push=1 → count=0, empty=1, full=0, data_out=0, pop_valid=0, top=0.
- Fill and overflow:
  - Push 1,2,…,8 on consecutive cycles → count steps 1..8; almost_full rises after the 7th push; full=1 and top=8 after the 8th.
  - A 9th push (data 9) → count=8, overflow=1, top=8.
- Drain and underflow:
  - From full, pop 8 times → data_out = 8,7,…,1 with pop_valid=1 each cycle; empty=1 after the last pop.
  - A 9th pop → underflow=1, pop_valid=0, data_out holds 1.
- Swap: push 3, push 5, then push+pop with data_in=A → data_out=5, pop_valid=1, count=2, top=A. Repeating the swap when full → no overflow.
- Pass-through: when empty, push+pop with data_in=C → data_out=C, pop_valid=1, count=0, no error flags.
- Flush and error clear:
  - With count=4 and overflow=1, assert flush together with push → count=0, overflow stays 1.
  - err_clr together with a pop on empty → underflow=1; err_clr alone on the next cycle → both error flags 0.

Source files
------------

// File: rtl/stack_lifo_param.sv
// Parametrised synchronous LIFO stack with occupancy count, almost-full threshold,
// push+pop swap, combinational peek, synchronous flush and sticky error flags.
module stack_lifo_param #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = DEPTH - 1,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             pop_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    mem_addr;
  logic             mem_we;
  logic [WIDTH-1:0] top_word;

  // Flags decode straight from the count register so they never lag an operation.
  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AFULL_LEVEL));

  assign wr_idx   = AW'(count);
  assign top_idx  = AW'(count - CW'(1));
  assign top_word = mem[top_idx];
  assign top      = empty ? '0 : top_word;

  // A swap overwrites the current top slot; a plain push writes one above it.
  assign mem_we   = !rst && !flush && push && (pop ? !empty : !full);
  assign mem_addr = pop ? top_idx : wr_idx;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      data_out  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      // Clearing first lets an error detected in the same cycle win.
      if (err_clr) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (flush) begin
        count <= '0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
          2'b01: begin
            if (empty) begin
              underflow <= 1'b1;
            end else begin
              data_out  <= top_word;
              count     <= count - CW'(1);
              pop_valid <= 1'b1;
            end
          end
          2'b11: begin
            data_out  <= empty ? data_in : top_word;
            pop_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stack_lifo_param.sv
// Directed bench for stack_lifo_param (WIDTH=4, DEPTH=8, AFULL_LEVEL=7); popped words
// are queued as expectations and checked by a separate monitor on pop_valid.
module tb_stack_lifo_param;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int AFULL = 7;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             flush = 1'b0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             pop_valid;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  int tests  = 0;
  int failed = 0;
  logic [WIDTH-1:0] exp_q [$];

  stack_lifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .err_clr(err_clr),
    .data_in(data_in), .data_out(data_out), .pop_valid(pop_valid), .top(top),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkState(input string tag, input int c, input logic f, input logic e,
                            input logic af, input logic ov, input logic uf, input logic [WIDTH-1:0] t);
    checkOutput({tag, ".count"}, 32'(count), 32'(c));
    checkOutput({tag, ".full"}, 32'(full), 32'(f));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(e));
    checkOutput({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(ov));
    checkOutput({tag, ".underflow"}, 32'(underflow), 32'(uf));
    checkOutput({tag, ".top"}, 32'(top), 32'(t));
  endtask

  // Drives one cycle of inputs, then returns #1 after the sampling edge with inputs idle.
  task automatic applyStimulus(input logic r, input logic p, input logic po, input logic fl,
                               input logic ec, input logic [WIDTH-1:0] d);
    rst = r; push = p; pop = po; flush = fl; err_clr = ec; data_in = d;
    @(posedge clk);
    #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0; data_in = '0;
  endtask

  always @(negedge clk) begin
    if (pop_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pop_valid", 32'(data_out), 32'hFFFF_FFFF);
      end else begin
        checkOutput("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2;
    // Reset held for two cycles with a push request pending
    applyStimulus(1, 1, 0, 0, 0, 4'h5);
    applyStimulus(1, 1, 0, 0, 0, 4'h5);
    checkState("reset", 0, 0, 1, 0, 0, 0, 4'h0);
    checkOutput("reset.data_out", 32'(data_out), 32'h0);
    checkOutput("reset.pop_valid", 32'(pop_valid), 32'h0);

    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 1, 0, 0, 0, WIDTH'(i));
      checkState($sformatf("fill%0d", i), i, i == 8, 0, i >= AFULL, 0, 0, WIDTH'(i));
    end
    applyStimulus(0, 1, 0, 0, 0, 4'h9);
    checkState("overflow", 8, 1, 0, 1, 1, 0, 4'h8);

    for (int i = 8; i >= 1; i--) begin
      exp_q.push_back(WIDTH'(i));
      applyStimulus(0, 0, 1, 0, 0, 4'h0);
      checkOutput($sformatf("drain%0d.pop_valid", i), 32'(pop_valid), 32'h1);
      checkState($sformatf("drain%0d", i), i - 1, 0, i == 1, (i - 1) >= AFULL, 1, 0, WIDTH'(i - 1));
    end
    applyStimulus(0, 0, 1, 0, 0, 4'h0);
    checkState("underflow", 0, 0, 1, 0, 1, 1, 4'h0);
    checkOutput("underflow.pop_valid", 32'(pop_valid), 32'h0);
    checkOutput("underflow.data_out", 32'(data_out), 32'h1);

    applyStimulus(0, 0, 0, 0, 1, 4'h0);
    checkState("err_clr1", 0, 0, 1, 0, 0, 0, 4'h0);

    // Swap on a partly filled stack
    applyStimulus(0, 1, 0, 0, 0, 4'h3);
    applyStimulus(0, 1, 0, 0, 0, 4'h5);
    exp_q.push_back(4'h5);
    applyStimulus(0, 1, 1, 0, 0, 4'hA);
    checkOutput("swap.pop_valid", 32'(pop_valid), 32'h1);
    checkState("swap", 2, 0, 0, 0, 0, 0, 4'hA);

    // Swap while full must not flag overflow; stack becomes 3,A,1,2,3,4,5,F
    for (int i = 1; i <= 6; i++) applyStimulus(0, 1, 0, 0, 0, WIDTH'(i));
    checkState("refill", 8, 1, 0, 1, 0, 0, 4'h6);
    exp_q.push_back(4'h6);
    applyStimulus(0, 1, 1, 0, 0, 4'hF);
    checkState("swap_full", 8, 1, 0, 1, 0, 0, 4'hF);

    applyStimulus(0, 1, 0, 0, 0, 4'h7);
    checkState("overflow2", 8, 1, 0, 1, 1, 0, 4'hF);
    exp_q.push_back(4'hF); exp_q.push_back(4'h5); exp_q.push_back(4'h4); exp_q.push_back(4'h3);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 4'h0);
    checkState("pop4", 4, 0, 0, 0, 1, 0, 4'h2);

    applyStimulus(0, 1, 0, 1, 0, 4'h9);
    checkState("flush", 0, 0, 1, 0, 1, 0, 4'h0);
    checkOutput("flush.pop_valid", 32'(pop_valid), 32'h0);
    checkOutput("flush.data_out", 32'(data_out), 32'h3);

    applyStimulus(0, 0, 1, 0, 1, 4'h0);
    checkState("clr_vs_err", 0, 0, 1, 0, 0, 1, 4'h0);
    applyStimulus(0, 0, 0, 0, 1, 4'h0);
    checkState("err_clr2", 0, 0, 1, 0, 0, 0, 4'h0);

    exp_q.push_back(4'hC);
    applyStimulus(0, 1, 1, 0, 0, 4'hC);
    checkOutput("passthru.pop_valid", 32'(pop_valid), 32'h1);
    checkState("passthru", 0, 0, 1, 0, 0, 0, 4'h0);

    // Reset in the middle of activity with a pop pending
    applyStimulus(0, 1, 0, 0, 0, 4'hB);
    applyStimulus(0, 1, 0, 0, 0, 4'hD);
    applyStimulus(1, 0, 1, 0, 0, 4'h0);
    checkState("mid_reset", 0, 0, 1, 0, 0, 0, 4'h0);
    checkOutput("mid_reset.data_out", 32'(data_out), 32'h0);
    checkOutput("mid_reset.pop_valid", 32'(pop_valid), 32'h0);

    @(negedge clk);
    #1;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
